// File: rtl/dmips_ctrl_pkg.sv
// Shared encodings for the dmips multicycle controller: opcodes, funct codes,
// ALU control codes, datapath mux selects and the controller state enum.
package dmips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;
  localparam logic [2:0] ALU_NOP = 3'b101;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTEX   = 4'd6,
    S_RTWB   = 4'd7,
    S_IMEX   = 4'd8,
    S_IMWB   = 4'd9,
    S_BREX   = 4'd10,
    S_JEX    = 4'd11
  } state_t;

endpackage

// File: rtl/alu_decoder.sv
// R-type funct field to ALU control code; unsupported functs map to the no-op code.
module alu_decoder
  import dmips_ctrl_pkg::*;
(
  input  logic [5:0] funct_i,
  output logic [2:0] alucont_o
);

  always_comb begin
    alucont_o = ALU_NOP;
    case (funct_i)
      FN_ADD:  alucont_o = ALU_ADD;
      FN_SUB:  alucont_o = ALU_SUB;
      FN_AND:  alucont_o = ALU_AND;
      FN_OR:   alucont_o = ALU_OR;
      FN_SLT:  alucont_o = ALU_SLT;
      default: alucont_o = ALU_NOP;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for the dmips multicycle datapath, with memory wait states
// in FETCH/MEMRD/MEMWR and a one-cycle illegal-opcode pulse in DECODE.
module multicycle_controller
  import dmips_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       iord,
  output logic       memread,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucont,
  output logic       illegal
);

  localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] WAIT_MAX = CW'(WAIT_CYCLES);

  state_t        state_q, state_d, nxt;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          bne_q, bne_d;
  logic          hold, illegal_c;
  logic          pcwrite_c, branch_c, irwrite_c, regwrite_c, memwrite_c, illegal_o_c;
  logic [2:0]    alu_rtype;

  alu_decoder u_alu_decoder (
    .funct_i   (funct),
    .alucont_o (alu_rtype)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      bne_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bne_q   <= bne_d;
    end
  end

  // Memory-access states stall until the counter reaches WAIT_MAX.
  assign hold = ((state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR))
                && (cnt_q != WAIT_MAX);

  always_comb begin
    nxt       = S_FETCH;
    illegal_c = 1'b0;
    case (state_q)
      S_FETCH:  nxt = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LB, OP_SB:   nxt = S_MEMADR;
          OP_RTYPE:       nxt = S_RTEX;
          OP_ADDI:        nxt = S_IMEX;
          OP_BEQ, OP_BNE: nxt = S_BREX;
          OP_J:           nxt = S_JEX;
          default: begin
            nxt       = S_FETCH;
            illegal_c = 1'b1;
          end
        endcase
      end
      S_MEMADR: nxt = (op == OP_SB) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  nxt = S_MEMWB;
      S_RTEX:   nxt = S_RTWB;
      S_IMEX:   nxt = S_IMWB;
      default:  nxt = S_FETCH;
    endcase
  end

  always_comb begin
    state_d = hold ? state_q : nxt;
    cnt_d   = hold ? cnt_q + 1'b1 : '0;
    bne_d   = (state_q == S_DECODE) ? (op == OP_BNE) : bne_q;
  end

  always_comb begin
    pcwrite_c   = 1'b0;
    branch_c    = 1'b0;
    iord        = 1'b0;
    memread     = 1'b0;
    memwrite_c  = 1'b0;
    irwrite_c   = 1'b0;
    regdst      = 1'b0;
    memtoreg    = 1'b0;
    regwrite_c  = 1'b0;
    alusrca     = 1'b0;
    alusrcb     = SRCB_B;
    pcsrc       = PCSRC_ALU;
    alucont     = ALU_ADD;
    illegal_o_c = 1'b0;
    case (state_q)
      S_FETCH: begin
        memread   = 1'b1;
        alusrcb   = SRCB_FOUR;
        irwrite_c = !hold;
        pcwrite_c = !hold;
      end
      S_DECODE: begin
        alusrcb     = SRCB_IMMSH;
        illegal_o_c = illegal_c;
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
      end
      S_MEMRD: begin
        iord    = 1'b1;
        memread = 1'b1;
      end
      S_MEMWB: begin
        memtoreg   = 1'b1;
        regwrite_c = 1'b1;
      end
      S_MEMWR: begin
        iord       = 1'b1;
        memwrite_c = 1'b1;
      end
      S_RTEX: begin
        alusrca = 1'b1;
        alucont = alu_rtype;
      end
      S_RTWB: begin
        regdst     = 1'b1;
        regwrite_c = 1'b1;
      end
      S_IMEX: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
      end
      S_IMWB:   regwrite_c = 1'b1;
      S_BREX: begin
        alusrca  = 1'b1;
        alucont  = ALU_SUB;
        pcsrc    = PCSRC_ALUOUT;
        branch_c = 1'b1;
      end
      S_JEX: begin
        pcsrc     = PCSRC_JUMP;
        pcwrite_c = 1'b1;
      end
      default: ;
    endcase
  end

  // Write enables are gated by rst_n so an asserted reset silences them at once.
  assign pcen     = rst_n & (pcwrite_c | (branch_c & (zero ^ bne_q)));
  assign irwrite  = rst_n & irwrite_c;
  assign regwrite = rst_n & regwrite_c;
  assign memwrite = rst_n & memwrite_c;
  assign illegal  = rst_n & illegal_o_c;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: one instance with no wait states,
// one with two wait states, checked against hand-derived output vectors.
module tb_multicycle_controller;

  logic       clk;
  logic       rst_n;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;

  logic       pcen0, iord0, mr0, mw0, irw0, rd0, m2r0, rw0, sa0, ill0;
  logic [1:0] sb0, pc0;
  logic [2:0] ac0;
  logic       pcen2, iord2, mr2, mw2, irw2, rd2, m2r2, rw2, sa2, ill2;
  logic [1:0] sb2, pc2;
  logic [2:0] ac2;

  int n_cmp = 0;
  int n_err = 0;

  multicycle_controller #(.WAIT_CYCLES(0)) u0 (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero),
    .pcen(pcen0), .iord(iord0), .memread(mr0), .memwrite(mw0), .irwrite(irw0),
    .regdst(rd0), .memtoreg(m2r0), .regwrite(rw0), .alusrca(sa0), .alusrcb(sb0),
    .pcsrc(pc0), .alucont(ac0), .illegal(ill0)
  );

  multicycle_controller #(.WAIT_CYCLES(2)) u2 (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero),
    .pcen(pcen2), .iord(iord2), .memread(mr2), .memwrite(mw2), .irwrite(irw2),
    .regdst(rd2), .memtoreg(m2r2), .regwrite(rw2), .alusrca(sa2), .alusrcb(sb2),
    .pcsrc(pc2), .alucont(ac2), .illegal(ill2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {pcen,iord,memread,memwrite,irwrite,regdst,memtoreg,regwrite,alusrca,alusrcb,pcsrc,alucont,illegal}
  logic [16:0] obs0, obs2;
  assign obs0 = {pcen0, iord0, mr0, mw0, irw0, rd0, m2r0, rw0, sa0, sb0, pc0, ac0, ill0};
  assign obs2 = {pcen2, iord2, mr2, mw2, irw2, rd2, m2r2, rw2, sa2, sb2, pc2, ac2, ill2};

  function automatic logic [16:0] ov(input logic pe, io, mr, mw, irw, rd, m2r, rw, sa,
                                     input logic [1:0] sb, pc, input logic [2:0] ac,
                                     input logic ill);
    return {pe, io, mr, mw, irw, rd, m2r, rw, sa, sb, pc, ac, ill};
  endfunction

  logic [16:0] V_RST, V_FWAIT, V_FLAST, V_DEC, V_DECILL, V_RTWB, V_MADR, V_MRD, V_MWB,
               V_MWR, V_IMEX, V_IMWB, V_JEX, V_BRT, V_BRN;

  function automatic logic [16:0] v_rtex(input logic [2:0] ac);
    return ov(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, ac, 0);
  endfunction

  task automatic chk(input string tag, input logic [16:0] obs, input logic [16:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply inputs, pulse reset, release mid-cycle; returns inside FETCH cycle 1.
  task automatic start(input logic [5:0] o, input logic [5:0] f, input logic z);
    op = o;
    funct = f;
    zero = z;
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    V_RST    = ov(0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 3'b010, 0);
    V_FWAIT  = V_RST;
    V_FLAST  = ov(1, 0, 1, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00, 3'b010, 0);
    V_DEC    = ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 3'b010, 0);
    V_DECILL = ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 3'b010, 1);
    V_RTWB   = ov(0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 3'b010, 0);
    V_MADR   = ov(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 3'b010, 0);
    V_MRD    = ov(0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b010, 0);
    V_MWB    = ov(0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 3'b010, 0);
    V_MWR    = ov(0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b010, 0);
    V_IMEX   = ov(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 3'b010, 0);
    V_IMWB   = ov(0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 3'b010, 0);
    V_JEX    = ov(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 3'b010, 0);
    V_BRT    = ov(1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 3'b110, 0);
    V_BRN    = ov(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 3'b110, 0);

    rst_n = 1'b0;
    op    = 6'b000000;
    funct = 6'b100000;
    zero  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_w0", obs0, V_RST);
    chk("reset_w2", obs2, V_RST);

    // add, no wait states
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("add_fetch", obs0, V_FLAST);
    tick(); chk("add_decode", obs0, V_DEC);
    tick(); chk("add_rtex", obs0, v_rtex(3'b010));
    tick(); chk("add_rtwb", obs0, V_RTWB);
    tick(); chk("add_next_fetch", obs0, V_FLAST);

    // lb, two wait states
    start(6'b100000, 6'b000000, 1'b0);
    chk("lb_f1", obs2, V_FWAIT);
    tick(); chk("lb_f2", obs2, V_FWAIT);
    tick(); chk("lb_f3", obs2, V_FLAST);
    tick(); chk("lb_decode", obs2, V_DEC);
    tick(); chk("lb_memadr", obs2, V_MADR);
    tick(); chk("lb_memrd1", obs2, V_MRD);
    tick(); chk("lb_memrd2", obs2, V_MRD);
    tick(); chk("lb_memrd3", obs2, V_MRD);
    tick(); chk("lb_memwb", obs2, V_MWB);
    tick(); chk("lb_next_fetch", obs2, V_FWAIT);

    // sb, two wait states
    start(6'b101000, 6'b000000, 1'b0);
    tick(); tick(); tick();
    chk("sb_decode", obs2, V_DEC);
    tick(); chk("sb_memadr", obs2, V_MADR);
    tick(); chk("sb_memwr1", obs2, V_MWR);
    tick(); chk("sb_memwr2", obs2, V_MWR);
    tick(); chk("sb_memwr3", obs2, V_MWR);
    tick(); chk("sb_next_fetch", obs2, V_FWAIT);

    // branches, no wait states
    start(6'b000100, 6'b000000, 1'b1);
    tick(); chk("beq_decode", obs0, V_DEC);
    tick(); chk("beq_z1_brex", obs0, V_BRT);
    tick(); chk("beq_next_fetch", obs0, V_FLAST);
    start(6'b000100, 6'b000000, 1'b0);
    tick(); tick(); chk("beq_z0_brex", obs0, V_BRN);
    start(6'b000101, 6'b000000, 1'b1);
    tick(); tick(); chk("bne_z1_brex", obs0, V_BRN);
    start(6'b000101, 6'b000000, 1'b0);
    tick(); tick(); chk("bne_z0_brex", obs0, V_BRT);

    // jump and addi
    start(6'b000010, 6'b000000, 1'b0);
    tick(); tick(); chk("j_jex", obs0, V_JEX);
    tick(); chk("j_next_fetch", obs0, V_FLAST);
    start(6'b001000, 6'b000000, 1'b0);
    tick(); tick(); chk("addi_imex", obs0, V_IMEX);
    tick(); chk("addi_imwb", obs0, V_IMWB);

    // illegal opcode
    start(6'b111111, 6'b000000, 1'b0);
    chk("ill_fetch", obs0, V_FLAST);
    tick(); chk("ill_decode", obs0, V_DECILL);
    tick(); chk("ill_back_fetch", obs0, V_FLAST);

    // R-type funct decode
    start(6'b000000, 6'b101010, 1'b0);
    tick(); tick(); chk("slt_rtex", obs0, v_rtex(3'b111));
    tick(); chk("slt_rtwb", obs0, V_RTWB);
    start(6'b000000, 6'b000000, 1'b0);
    tick(); tick(); chk("nop_rtex", obs0, v_rtex(3'b101));
    tick(); chk("nop_rtwb", obs0, V_RTWB);

    // reset in the middle of MEMRD, two wait states
    start(6'b100000, 6'b000000, 1'b0);
    repeat (5) tick();
    chk("abort_memrd1", obs2, V_MRD);
    tick();
    chk("abort_memrd2", obs2, V_MRD);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_reset", obs2, V_RST);
    tick();
    chk("abort_reset_held", obs2, V_RST);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("abort_f1", obs2, V_FWAIT);
    tick(); chk("abort_f2", obs2, V_FWAIT);
    tick(); chk("abort_f3", obs2, V_FLAST);
    tick(); chk("abort_decode", obs2, V_DEC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
